// File: rtl/aurora_wb_burst_master.sv
// Aurora UFC command/data streams to Wishbone single and incrementing-burst accesses.
// Build with AURORA_WB_WRITE_STATUS_EN defined to emit one status word per write command.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | waiting for a command (writes also wait for their first word)
// ISSUE     | current beat on Wishbone; cyc held low between beats and retries
// READ_RESP | read word (or ERR_WORD) held on m_resp until accepted
// DRAIN     | write aborted, consuming the remaining beats' data words
// STATUS    | write status word held on m_resp until accepted (status build)
// DONE      | one-cycle s_addr_tready pulse, then back to IDLE
module aurora_wb_burst_master #(
    parameter int          ADDR_BITS      = 25,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          RETRY_MAX      = 3,
    parameter logic [31:0] ERR_WORD       = 32'hBADACCE5
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [31:0]          s_addr_tdata,
    input  logic                 s_addr_tvalid,
    output logic                 s_addr_tready,
    input  logic [31:0]          s_data_tdata,
    input  logic                 s_data_tvalid,
    output logic                 s_data_tready,
    output logic [31:0]          m_resp_tdata,
    output logic                 m_resp_tvalid,
    input  logic                 m_resp_tready,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [ADDR_BITS-1:0] wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_rty_i
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_READ_RESP = 3'd2,
        S_DRAIN     = 3'd3,
`ifdef AURORA_WB_WRITE_STATUS_EN
        S_STATUS    = 3'd5,
`endif
        S_DONE      = 3'd4
    } state_t;

`ifdef AURORA_WB_WRITE_STATUS_EN
    localparam state_t S_WR_END = S_STATUS;
`else
    localparam state_t S_WR_END = S_DONE;
`endif

    localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] RETRY_LIMIT = 32'(RETRY_MAX);

    state_t      state;
    logic        rd;
    logic        abort;
    logic [4:0]  beats_left;
    logic [31:0] retry_cnt;
    logic [31:0] to_cnt;
`ifdef AURORA_WB_WRITE_STATUS_EN
    logic [3:0]  beats_done;
    logic [1:0]  cause;
`endif

    logic timeout_hit;
    logic rty_ok;
    logic beat_fail;
    logic beat_end;
    logic unused_cmd_bits;

    // Only part of the command word is decoded (bits [1:0] and any bits above the address).
    assign unused_cmd_bits = ^s_addr_tdata;

    assign wb_stb_o = wb_cyc_o;
    assign wb_dat_o = s_data_tdata;

    // Termination priority is ack > err > rty; timeout only counts on a silent cycle.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
        rty_ok      = wb_rty_i && (retry_cnt < RETRY_LIMIT);
        beat_fail   = !wb_ack_i &&
                      (wb_err_i || (wb_rty_i && !rty_ok) || (!wb_rty_i && timeout_hit));
        beat_end    = wb_ack_i || beat_fail;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            rd            <= 1'b0;
            abort         <= 1'b0;
            beats_left    <= 5'd0;
            retry_cnt     <= 32'd0;
            to_cnt        <= 32'd0;
            s_addr_tready <= 1'b0;
            s_data_tready <= 1'b0;
            m_resp_tvalid <= 1'b0;
            m_resp_tdata  <= 32'd0;
            wb_cyc_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= '0;
            wb_sel_o      <= 4'h0;
`ifdef AURORA_WB_WRITE_STATUS_EN
            beats_done    <= 4'd0;
            cause         <= 2'd0;
`endif
        end else begin
            s_addr_tready <= 1'b0;
            s_data_tready <= 1'b0;
            case (state)
                S_IDLE: begin
                    // s_addr_tready still high means the last command is just being consumed
                    if (s_addr_tvalid && !s_addr_tready && (s_addr_tdata[31] || s_data_tvalid)) begin
                        rd         <= s_addr_tdata[31];
                        beats_left <= {1'b0, s_addr_tdata[30:27]} + 5'd1;
                        wb_adr_o   <= {s_addr_tdata[ADDR_BITS-1:2], 2'b00};
                        wb_we_o    <= !s_addr_tdata[31];
                        wb_sel_o   <= s_addr_tdata[31] ? 4'h0 : 4'hF;
                        abort      <= 1'b0;
                        retry_cnt  <= 32'd0;
                        to_cnt     <= 32'd0;
`ifdef AURORA_WB_WRITE_STATUS_EN
                        beats_done <= 4'd0;
                        cause      <= 2'd0;
`endif
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!wb_cyc_o) begin
                        // a word whose tready is high right now belongs to the previous beat
                        if (rd || (s_data_tvalid && !s_data_tready))
                            wb_cyc_o <= 1'b1;
                    end else if (beat_end) begin
                        wb_cyc_o   <= 1'b0;
                        retry_cnt  <= 32'd0;
                        to_cnt     <= 32'd0;
                        wb_adr_o   <= wb_adr_o + ADDR_BITS'(4);
                        beats_left <= beats_left - 5'd1;
                        if (beat_fail)
                            abort <= 1'b1;
`ifdef AURORA_WB_WRITE_STATUS_EN
                        cause <= wb_ack_i ? 2'd0 : wb_err_i ? 2'd1 : wb_rty_i ? 2'd2 : 2'd3;
                        if (!rd && !beat_fail)
                            beats_done <= beats_done + 4'd1;
`endif
                        if (rd) begin
                            m_resp_tdata  <= beat_fail ? ERR_WORD : wb_dat_i;
                            m_resp_tvalid <= 1'b1;
                            state         <= S_READ_RESP;
                        end else begin
                            s_data_tready <= 1'b1;
                            if (beats_left == 5'd1)
                                state <= S_WR_END;
                            else if (beat_fail)
                                state <= S_DRAIN;
                        end
                    end else if (rty_ok) begin
                        wb_cyc_o  <= 1'b0;
                        retry_cnt <= retry_cnt + 32'd1;
                        to_cnt    <= 32'd0;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                S_READ_RESP: begin
                    if (m_resp_tready) begin
                        m_resp_tvalid <= 1'b0;
                        state <= (beats_left != 5'd0 && !abort) ? S_ISSUE : S_DONE;
                    end
                end
                S_DRAIN: begin
                    if (beats_left == 5'd0) begin
                        state <= S_WR_END;
                    end else if (s_data_tvalid && !s_data_tready) begin
                        s_data_tready <= 1'b1;
                        beats_left    <= beats_left - 5'd1;
                    end
                end
`ifdef AURORA_WB_WRITE_STATUS_EN
                S_STATUS: begin
                    if (!m_resp_tvalid) begin
                        m_resp_tdata  <= {abort, beats_done, 25'd0, cause};
                        m_resp_tvalid <= 1'b1;
                    end else if (m_resp_tready) begin
                        m_resp_tvalid <= 1'b0;
                        state         <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    s_addr_tready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
